// File: rtl/sme_job_scheduler.sv
// rtl/sme_job_scheduler.sv - round-robin job scheduler sharing one KMP match engine; optional watchdog via SME_SCHED_WDT_EN
module sme_job_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int STR_AW  = 6,
    parameter int PAT_AW  = 4,
    parameter int GAP_CYC = 2
`ifdef SME_SCHED_WDT_EN
    ,
    parameter int WDT_CYC = 255
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*STR_AW-1:0]   req_str_last_idx,
    input  logic [NUM_REQ*PAT_AW-1:0]   req_pat_last_idx,
    output logic                        eng_input_valid,
    output logic [STR_AW-1:0]           eng_str_last_idx,
    output logic [PAT_AW-1:0]           eng_pat_last_idx,
    input  logic                        eng_o_valid,
    input  logic                        eng_o_match,
    input  logic [STR_AW-1:0]           eng_o_match_idx,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic                        rsp_match,
    output logic [STR_AW-1:0]           rsp_match_idx,
    output logic                        rsp_err,
    output logic                        busy
);

    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int CMP_W = STR_AW + PAT_AW;
`ifdef SME_SCHED_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYC + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [RR_W-1:0]     rr_q, rr_d;
    logic [RR_W-1:0]     owner_q, owner_d;
    logic [STR_AW-1:0]   str_q, str_d;
    logic [PAT_AW-1:0]   pat_q, pat_d;
    logic                match_q, match_d;
    logic [STR_AW-1:0]   idx_q, idx_d;
    logic                skip_q, skip_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
`ifdef SME_SCHED_WDT_EN
    logic [WDT_W-1:0]    wdt_q, wdt_d;
    logic                err_q, err_d;
`endif

    logic                grant_found;
    logic [RR_W-1:0]     grant_idx;
    logic [RR_W-1:0]     rr_after_grant;
    logic [STR_AW-1:0]   sel_str;
    logic [PAT_AW-1:0]   sel_pat;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [NUM_REQ-1:0]  owner_onehot;
    logic                owner_ack;
    logic                pat_too_long;

    // Round-robin search: first asserted request at or after rr_q, wrapping at NUM_REQ
    always_comb begin
        logic [RR_W:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + (RR_W+1)'(i);
            if (cand >= (RR_W+1)'(NUM_REQ)) begin
                cand = cand - (RR_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[RR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[RR_W-1:0];
            end
        end
    end

    // Select the winner's lengths and build one-hot grant/owner vectors
    always_comb begin
        sel_str      = '0;
        sel_pat      = '0;
        grant_onehot = '0;
        owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == RR_W'(i)) begin
                sel_str = req_str_last_idx[i*STR_AW +: STR_AW];
                sel_pat = req_pat_last_idx[i*PAT_AW +: PAT_AW];
            end
            grant_onehot[i] = grant_found && (grant_idx == RR_W'(i));
            owner_onehot[i] = (owner_q == RR_W'(i));
        end
    end

    // Pointer wraps explicitly since NUM_REQ need not be a power of two
    assign rr_after_grant = (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + RR_W'(1);
    assign pat_too_long   = CMP_W'(sel_pat) > CMP_W'(sel_str);
    assign owner_ack      = |(rsp_ready & owner_onehot);

    // Next-state and datapath capture for the job FSM
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        str_d   = str_q;
        pat_d   = pat_q;
        match_d = match_q;
        idx_d   = idx_q;
        skip_d  = skip_q;
        gap_d   = gap_q;
`ifdef SME_SCHED_WDT_EN
        wdt_d   = wdt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    owner_d = grant_idx;
                    rr_d    = rr_after_grant;
                    str_d   = sel_str;
                    pat_d   = sel_pat;
`ifdef SME_SCHED_WDT_EN
                    err_d   = 1'b0;
                    wdt_d   = '0;
`endif
                    if (pat_too_long) begin
                        // Cannot match: answer immediately without touching the engine
                        match_d = 1'b0;
                        idx_d   = '0;
                        skip_d  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        skip_d  = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (eng_o_valid) begin
                    match_d = eng_o_match;
                    idx_d   = eng_o_match ? eng_o_match_idx : '0;
                    state_d = ST_RESP;
`ifdef SME_SCHED_WDT_EN
                end else if (wdt_q == WDT_W'(WDT_CYC)) begin
                    match_d = 1'b0;
                    idx_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wdt_d   = wdt_q + WDT_W'(1);
`endif
                end
            end
            ST_RESP: begin
                if (owner_ack) begin
                    gap_d   = '0;
                    state_d = skip_q ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d   = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and job registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            str_q   <= '0;
            pat_q   <= '0;
            match_q <= 1'b0;
            idx_q   <= '0;
            skip_q  <= 1'b0;
            gap_q   <= '0;
`ifdef SME_SCHED_WDT_EN
            wdt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            str_q   <= str_d;
            pat_q   <= pat_d;
            match_q <= match_d;
            idx_q   <= idx_d;
            skip_q  <= skip_d;
            gap_q   <= gap_d;
`ifdef SME_SCHED_WDT_EN
            wdt_q   <= wdt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign req_ready        = (state_q == ST_IDLE) ? grant_onehot : '0;
    assign eng_input_valid  = (state_q == ST_RUN);
    assign eng_str_last_idx = str_q;
    assign eng_pat_last_idx = pat_q;
    assign rsp_valid        = (state_q == ST_RESP) ? owner_onehot : '0;
    assign rsp_match        = (state_q == ST_RESP) && match_q;
    assign rsp_match_idx    = (state_q == ST_RESP) ? idx_q : '0;
`ifdef SME_SCHED_WDT_EN
    assign rsp_err          = (state_q == ST_RESP) && err_q;
`else
    assign rsp_err          = 1'b0;
`endif
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sme_job_scheduler.sv
// tb/tb_sme_job_scheduler.sv - self-checking bench for sme_job_scheduler with a transaction-level model
module tb_sme_job_scheduler;

    localparam int N   = 4;
    localparam int SW  = 6;
    localparam int PW  = 4;
    localparam int GAP = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid, rsp_ready;
    logic [N*SW-1:0] req_str;
    logic [N*PW-1:0] req_pat;
    logic            eov, eom;
    logic [SW-1:0]   eomi;
    logic [N-1:0]    req_ready, rsp_valid;
    logic            eng_input_valid, rsp_match, rsp_err, busy;
    logic [SW-1:0]   eng_str, rsp_match_idx;
    logic [PW-1:0]   eng_pat;

    always #5 clk = ~clk;

    sme_job_scheduler #(.NUM_REQ(N), .STR_AW(SW), .PAT_AW(PW), .GAP_CYC(GAP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_str_last_idx(req_str), .req_pat_last_idx(req_pat),
        .eng_input_valid(eng_input_valid), .eng_str_last_idx(eng_str), .eng_pat_last_idx(eng_pat),
        .eng_o_valid(eov), .eng_o_match(eom), .eng_o_match_idx(eomi),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_match(rsp_match), .rsp_match_idx(rsp_match_idx), .rsp_err(rsp_err), .busy(busy)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input int s, input int p);
        req_str[k*SW +: SW] = SW'(s);
        req_pat[k*PW +: PW] = PW'(p);
    endtask

    // Model: job phase 0 idle, 1 engine running, 2 answering, 3 quiet gap
    int m_mode, m_owner, m_rr, m_str, m_pat, m_match, m_idx, m_skip, m_gap;

    always @(negedge clk) begin : model
        int g;
        logic [N-1:0] er, ev;
        if (reset) begin
            m_mode = 0; m_owner = 0; m_rr = 0; m_str = 0; m_pat = 0;
            m_match = 0; m_idx = 0; m_skip = 0; m_gap = 0;
            chk("rst_busy", busy, 0);
            chk("rst_eng_valid", eng_input_valid, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_eng_str", eng_str, 0);
            chk("rst_eng_pat", eng_pat, 0);
            chk("rst_rsp_match", rsp_match, 0);
            chk("rst_rsp_idx", rsp_match_idx, 0);
            chk("rst_rsp_err", rsp_err, 0);
        end else begin
            g = -1;
            if (m_mode == 0)
                for (int i = 0; i < N; i++)
                    if (g < 0 && req_valid[(m_rr + i) % N]) g = (m_rr + i) % N;
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            ev = '0;
            if (m_mode == 2) ev[m_owner] = 1'b1;
            chk("m_req_ready", req_ready, er);
            chk("m_eng_valid", eng_input_valid, m_mode == 1);
            if (m_mode == 1) begin
                chk("m_eng_str", eng_str, m_str);
                chk("m_eng_pat", eng_pat, m_pat);
            end
            chk("m_rsp_valid", rsp_valid, ev);
            if (m_mode == 2) begin
                chk("m_rsp_match", rsp_match, m_match);
                chk("m_rsp_idx", rsp_match_idx, m_idx);
            end
            chk("m_rsp_err", rsp_err, 0);
            chk("m_busy", busy, m_mode != 0);
            case (m_mode)
                0: if (g >= 0) begin
                    m_owner = g;
                    m_rr    = (g + 1) % N;
                    m_str   = int'(req_str[g*SW +: SW]);
                    m_pat   = int'(req_pat[g*PW +: PW]);
                    if (m_pat > m_str) begin
                        m_mode = 2; m_match = 0; m_idx = 0; m_skip = 1;
                    end else begin
                        m_mode = 1; m_skip = 0;
                    end
                end
                1: if (eov) begin
                    m_match = int'(eom);
                    m_idx   = eom ? int'(eomi) : 0;
                    m_mode  = 2;
                end
                2: if (rsp_ready[m_owner]) begin
                    if (m_skip != 0) m_mode = 0;
                    else begin m_mode = 3; m_gap = GAP; end
                end
                default: begin
                    m_gap = m_gap - 1;
                    if (m_gap == 0) m_mode = 0;
                end
            endcase
        end
    end

    logic [N-1:0] exp_rr [5];
    int n, run_cnt, delay;

    initial begin
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
        req_valid = '0; rsp_ready = '0; req_str = '0; req_pat = '0;
        eov = 1'b0; eom = 1'b0; eomi = '0; reset = 1'b1;
        step(); step();
        chk("reset_busy", busy, 0);
        chk("reset_eng_valid", eng_input_valid, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        reset = 1'b0;

        // single job on requester 1
        step();
        req_valid = 4'b0010; set_slot(1, 15, 3);
        #1 chk("single_req_ready", req_ready, 4'b0010);
        step(); req_valid = '0;
        #1 chk("single_eng_valid", eng_input_valid, 1);
        chk("single_eng_str", eng_str, 15);
        chk("single_eng_pat", eng_pat, 3);
        eov = 1'b1; eom = 1'b1; eomi = 6'd7;
        step(); eov = 1'b0; eom = 1'b0; eomi = '0;
        #1 chk("single_rsp_valid", rsp_valid, 4'b0010);
        chk("single_rsp_match", rsp_match, 1);
        chk("single_rsp_idx", rsp_match_idx, 7);
        chk("single_rsp_err", rsp_err, 0);
        rsp_ready = 4'b0010;
        step(); rsp_ready = '0;
        #1 chk("gap1_busy", busy, 1);
        chk("gap1_eng_valid", eng_input_valid, 0);
        step();
        #1 chk("gap2_busy", busy, 1);
        step();
        #1 chk("gap_done_idle", busy, 0);

        // pattern longer than string on requester 2 (pointer now at 2)
        req_valid = 4'b0100; set_slot(2, 2, 5);
        #1 chk("skip_req_ready", req_ready, 4'b0100);
        step(); req_valid = '0;
        #1 chk("skip_rsp_valid", rsp_valid, 4'b0100);
        chk("skip_eng_valid", eng_input_valid, 0);
        chk("skip_match", rsp_match, 0);
        chk("skip_idx", rsp_match_idx, 0);
        rsp_ready = 4'b0100;
        step(); rsp_ready = '0;
        #1 chk("skip_no_gap", busy, 0);

        // no-match result with backpressure on requester 3
        req_valid = 4'b1000; set_slot(3, 20, 4);
        #1 chk("bp_req_ready", req_ready, 4'b1000);
        step(); req_valid = '0;
        eov = 1'b1; eom = 1'b0; eomi = 6'd9;
        #1 chk("bp_eng_valid", eng_input_valid, 1);
        step(); eov = 1'b0; eomi = '0;
        rsp_ready = 4'b0111; req_valid = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_rsp_valid", rsp_valid, 4'b1000);
            chk("bp_match", rsp_match, 0);
            chk("bp_idx", rsp_match_idx, 0);
            chk("bp_no_grant", req_ready, 0);
            step();
        end
        rsp_ready = 4'b1000; req_valid = '0;
        #1 chk("bp_rsp_valid_last", rsp_valid, 4'b1000);
        step();

        // round robin with every requester asking
        rsp_ready = 4'b1111; req_valid = 4'b1111;
        for (int k = 0; k < N; k++) set_slot(k, 30, 3);
        for (int j = 0; j < 5; j++) begin
            n = 0;
            #1;
            while (req_ready == '0 && n < 20) begin
                step(); #1; n++;
            end
            if (j > 0) chk("rr_gap_wait", n, GAP + 1);
            chk("rr_grant", req_ready, exp_rr[j]);
            step(); eov = 1'b1; eom = 1'b1; eomi = SW'(j);
            #1 chk("rr_eng_valid", eng_input_valid, 1);
            step(); eov = 1'b0;
            #1 chk("rr_rsp_valid", rsp_valid, exp_rr[j]);
        end
        req_valid = '0;
        n = 0;
        while (busy && n < 10) begin step(); n++; end
        chk("rr_drain", busy, 0);

        // asynchronous reset in the middle of a job
        req_valid = 4'b0100; set_slot(2, 10, 2);
        #1 chk("mid_req_ready", req_ready, 4'b0100);
        step(); req_valid = '0;
        #1 chk("mid_eng_valid", eng_input_valid, 1);
        #1 reset = 1'b1;
        #1 chk("async_eng_valid", eng_input_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_eng_str", eng_str, 0);
        chk("async_rsp_valid", rsp_valid, 0);
        step(); reset = 1'b0;
        req_valid = 4'b1111;
        #1 chk("post_rst_grant", req_ready, 4'b0001);
        step(); req_valid = '0; eov = 1'b1; eom = 1'b0;
        step(); eov = 1'b0; rsp_ready = 4'b0001;
        step(); rsp_ready = '0;

        // randomized traffic; the model checks every cycle
        run_cnt = 0; delay = 1;
        for (int c = 0; c < 4000; c++) begin
            step();
            req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            rsp_ready = N'($urandom);
            for (int k = 0; k < N; k++)
                set_slot(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 63),
                         $urandom_range(0, 15));
            eom  = 1'($urandom);
            eomi = SW'($urandom);
            if (eng_input_valid) begin
                if (run_cnt == 0) delay = $urandom_range(1, 6);
                run_cnt++;
                eov = (run_cnt == delay);
            end else begin
                run_cnt = 0;
                eov = ($urandom_range(0, 7) == 0);
            end
        end
        req_valid = '0; rsp_ready = '1; eov = 1'b0;
        step(); step(); step(); step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
